// File: rtl/input_conditioner_pkg.sv
// Shared button definitions for the player controls; also used by the game-state logic.
// Bit order on every button bus: {left,right,up,down,chop,carry}.
package input_conditioner_pkg;

   localparam int NUM_BTN   = 6;
   localparam int BTN_LEFT  = 5;
   localparam int BTN_RIGHT = 4;
   localparam int BTN_UP    = 3;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_CHOP  = 1;
   localparam int BTN_CARRY = 0;

   typedef logic [NUM_BTN-1:0] btn_vec_t;

   localparam int                HOLD_W   = 8;
   localparam logic [HOLD_W-1:0] HOLD_MAX = 8'hFF;

endpackage

// File: rtl/input_conditioner_if.sv
// Button/vsync inputs and conditioned per-clock and per-frame outputs of the input conditioner.
// master = producer of raw inputs / consumer of outputs, slave = the conditioner itself.
interface input_conditioner_if;
   import input_conditioner_pkg::*;

   btn_vec_t btn_in;
   logic     vsync_in;
   btn_vec_t level_out;
   btn_vec_t press_out;
   btn_vec_t frame_level;
   btn_vec_t frame_press;
   logic     frame_tick;

   modport master (
      output btn_in,
      output vsync_in,
      input  level_out,
      input  press_out,
      input  frame_level,
      input  frame_press,
      input  frame_tick
   );

   modport slave (
      input  btn_in,
      input  vsync_in,
      output level_out,
      output press_out,
      output frame_level,
      output frame_press,
      output frame_tick
   );

endinterface

// File: rtl/input_conditioner_debounce_bit.sv
// One button: 2-flop synchronizer plus hold-time debounce and rising-edge press pulse.
// A clean edge reaches o_level/o_press 2 + DEBOUNCE_CYCLES clocks after it arrives.
module input_conditioner_debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 650000
) (
   input  logic clock,
   input  logic reset,
   input  logic i_raw,
   output logic o_level,
   output logic o_press,
   output logic o_level_nxt,
   output logic o_press_nxt
);

   localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_stable;
   logic          r_press;
   logic [CW-1:0] r_cnt;
   logic          w_differ;
   logic          w_flip;
   logic          w_level_nxt;
   logic          w_press_nxt;

   assign w_differ    = r_sync2 ^ r_stable;
   assign w_flip      = w_differ && (r_cnt == LAST);
   assign w_level_nxt = r_stable ^ w_flip;
   assign w_press_nxt = w_flip & ~r_stable;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_press  <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1  <= i_raw;
         r_sync2  <= r_sync1;
         r_stable <= w_level_nxt;
         r_press  <= w_press_nxt;
         // any sample agreeing with the accepted level restarts the hold window
         if (!w_differ || w_flip)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_level     = r_stable;
   assign o_press     = r_press;
   assign o_level_nxt = w_level_nxt;
   assign o_press_nxt = w_press_nxt;

endmodule

// File: rtl/input_conditioner.sv
// Debounced button levels/presses per clock, plus per-frame snapshots with sticky presses and auto-repeat.
// Frame outputs refresh 3 clocks after the raw vsync rising edge; frame_tick marks the refresh cycle.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int       DEBOUNCE_CYCLES     = 650000,
   parameter int       REPEAT_DELAY_FRAMES = 30,
   parameter int       REPEAT_RATE_FRAMES  = 6,
   parameter btn_vec_t REPEAT_MASK         = 6'b001100
) (
   input  logic          clock,
   input  logic          reset,
   input_conditioner_if.slave bus
);

   localparam logic [HOLD_W-1:0] HOLD_DELAY = HOLD_W'(REPEAT_DELAY_FRAMES);
   localparam logic [HOLD_W-1:0] HOLD_RATE  = HOLD_W'(REPEAT_RATE_FRAMES);

   btn_vec_t          w_level;
   btn_vec_t          w_press;
   btn_vec_t          w_level_nxt;
   btn_vec_t          w_press_nxt;
   btn_vec_t          w_repeat;
   logic              w_update;
   logic [HOLD_W-1:0] w_hold_inc [NUM_BTN];
   logic [HOLD_W-1:0] w_rate_inc [NUM_BTN];

   logic              r_vs1;
   logic              r_vs2;
   logic              r_vs3;
   logic              r_frame_tick;
   btn_vec_t          r_frame_level;
   btn_vec_t          r_frame_press;
   btn_vec_t          r_pend;
   logic [HOLD_W-1:0] r_hold [NUM_BTN];
   logic [HOLD_W-1:0] r_rate [NUM_BTN];

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      input_conditioner_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clock       (clock),
         .reset       (reset),
         .i_raw       (bus.btn_in[gi]),
         .o_level     (w_level[gi]),
         .o_press     (w_press[gi]),
         .o_level_nxt (w_level_nxt[gi]),
         .o_press_nxt (w_press_nxt[gi])
      );
   end

   // end of the active-low sync pulse
   assign w_update = r_vs2 & ~r_vs3;

   // Snapshot describes the tick cycle itself, so it is built from the values
   // level_out/press_out will carry in that cycle.
   always_comb begin
      for (int i = 0; i < NUM_BTN; i++) begin
         w_hold_inc[i] = (r_hold[i] == HOLD_MAX) ? HOLD_MAX : r_hold[i] + 1'b1;
         w_rate_inc[i] = r_rate[i] + 1'b1;
         w_repeat[i]   = 1'b0;
         if (REPEAT_MASK[i] && w_level_nxt[i] && w_update)
            w_repeat[i] = (w_hold_inc[i] == HOLD_DELAY) ||
                          ((w_hold_inc[i] > HOLD_DELAY) && (w_rate_inc[i] == HOLD_RATE));
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_vs1         <= 1'b0;
         r_vs2         <= 1'b0;
         r_vs3         <= 1'b0;
         r_frame_tick  <= 1'b0;
         r_frame_level <= '0;
         r_frame_press <= '0;
         r_pend        <= '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            r_hold[i] <= '0;
            r_rate[i] <= '0;
         end
      end else begin
         r_vs1        <= bus.vsync_in;
         r_vs2        <= r_vs1;
         r_vs3        <= r_vs2;
         r_frame_tick <= w_update;
         if (w_update) begin
            r_frame_level <= w_level_nxt;
            r_frame_press <= r_pend | w_press_nxt | w_repeat;
            r_pend        <= '0;
         end else begin
            r_pend        <= r_pend | w_press_nxt;
         end
         // rate counter restarts at the first repeat and after each later one
         for (int i = 0; i < NUM_BTN; i++) begin
            if (!w_level_nxt[i]) begin
               r_hold[i] <= '0;
               r_rate[i] <= '0;
            end else if (w_update) begin
               r_hold[i] <= w_hold_inc[i];
               if ((w_hold_inc[i] <= HOLD_DELAY) || (w_rate_inc[i] == HOLD_RATE))
                  r_rate[i] <= '0;
               else
                  r_rate[i] <= w_rate_inc[i];
            end
         end
      end
   end

   assign bus.level_out   = w_level;
   assign bus.press_out   = w_press;
   assign bus.frame_level = r_frame_level;
   assign bus.frame_press = r_frame_press;
   assign bus.frame_tick  = r_frame_tick;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: reference model feeds an expected-snapshot queue, a monitor
// compares every cycle, and directed phases cover bounce, glitch, taps, repeat and reset.
module tb_input_conditioner;
   import input_conditioner_pkg::*;

   localparam int       DB    = 16;
   localparam int       RD    = 4;
   localparam int       RR    = 2;
   localparam btn_vec_t RMASK = 6'b001100;

   logic clock = 1'b0;
   logic reset = 1'b1;

   input_conditioner_if bus ();

   input_conditioner #(
      .DEBOUNCE_CYCLES     (DB),
      .REPEAT_DELAY_FRAMES (RD),
      .REPEAT_RATE_FRAMES  (RR),
      .REPEAT_MASK         (RMASK)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      btn_vec_t lvl;
      btn_vec_t prs;
   } snap_t;

   btn_vec_t bhist[$];
   logic     vhist[$];
   btn_vec_t m_stable = '0;
   btn_vec_t m_press  = '0;
   btn_vec_t m_pend   = '0;
   int       m_held[NUM_BTN];
   snap_t    exp_q[$];

   function automatic btn_vec_t bpast(input int m);
      return (bhist.size() >= m) ? bhist[bhist.size() - m] : '0;
   endfunction

   function automatic logic vpast(input int m);
      return (vhist.size() >= m) ? vhist[vhist.size() - m] : 1'b0;
   endfunction

   always @(posedge clock) begin
      btn_vec_t ns, rep, smp;
      logic     upd, all_diff;
      if (reset) begin
         bhist.delete();
         vhist.delete();
         m_stable = '0;
         m_press  = '0;
         m_pend   = '0;
         for (int i = 0; i < NUM_BTN; i++) m_held[i] = 0;
         exp_q.delete();
      end else begin
         // a bit is accepted once its synchronized value has disagreed for DB samples in a row
         ns = m_stable;
         for (int i = 0; i < NUM_BTN; i++) begin
            all_diff = 1'b1;
            for (int j = 0; j < DB; j++) begin
               smp = bpast(2 + j);
               if (smp[i] == m_stable[i]) all_diff = 1'b0;
            end
            if (all_diff) ns[i] = ~m_stable[i];
         end
         m_press  = ns & ~m_stable;
         m_stable = ns;
         upd = vpast(2) && !vpast(3);
         rep = '0;
         for (int i = 0; i < NUM_BTN; i++) begin
            if (!m_stable[i]) m_held[i] = 0;
            else if (upd) begin
               m_held[i]++;
               if (RMASK[i] && m_held[i] >= RD && ((m_held[i] - RD) % RR) == 0) rep[i] = 1'b1;
            end
         end
         if (upd) begin
            exp_q.push_back('{lvl: m_stable, prs: m_pend | m_press | rep});
            m_pend = '0;
         end else begin
            m_pend = m_pend | m_press;
         end
         bhist.push_back(bus.btn_in);
         vhist.push_back(bus.vsync_in);
         if (bhist.size() > 64) begin
            void'(bhist.pop_front());
            void'(vhist.pop_front());
         end
      end
   end

   // ---------------- monitor ----------------
   int press_cnt[NUM_BTN];

   initial begin : monitor
      btn_vec_t last_l, last_p;
      snap_t    s;
      logic     rs, exp_tick;
      last_l = '0;
      last_p = '0;
      for (int i = 0; i < NUM_BTN; i++) press_cnt[i] = 0;
      forever begin
         @(posedge clock);
         rs = reset;
         #1;
         if (rs) begin
            last_l = '0;
            last_p = '0;
         end
         exp_tick = (exp_q.size() != 0);
         check("frame_tick", bus.frame_tick, exp_tick);
         if (exp_tick) begin
            s = exp_q.pop_front();
            last_l = s.lvl;
            last_p = s.prs;
         end
         check("level_out", bus.level_out, m_stable);
         check("press_out", bus.press_out, m_press);
         check("frame_level", bus.frame_level, last_l);
         check("frame_press", bus.frame_press, last_p);
         for (int i = 0; i < NUM_BTN; i++) if (bus.press_out[i] === 1'b1) press_cnt[i]++;
      end
   end

   // ---------------- vsync generator ----------------
   bit vs_run   = 1'b1;
   int kick_req = 0;

   initial begin : vsync_gen
      int kick_seen;
      kick_seen = 0;
      bus.vsync_in = 1'b1;
      forever begin
         @(negedge clock);
         if (vs_run || kick_req != kick_seen) begin
            kick_seen = kick_req;
            bus.vsync_in = 1'b0;
            repeat (3) @(negedge clock);
            bus.vsync_in = 1'b1;
            if (vs_run) repeat ($urandom_range(30, 60)) @(negedge clock);
         end
      end
   end

   task automatic wait_tick(input string name);
      int n;
      n = 0;
      do begin
         @(posedge clock);
         #1;
         n++;
      end while (bus.frame_tick !== 1'b1 && n < 300);
      check(name, bus.frame_tick, 1'b1);
   endtask

   // ---------------- stimulus ----------------
   initial begin : stim
      int  cnt, p0, ticks, hits3, hits1;
      bit  seen;
      bus.btn_in = '0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);

      // bounce on chop, then a clean hold
      p0 = press_cnt[BTN_CHOP];
      for (int k = 0; k < 20; k++) begin
         bus.btn_in[BTN_CHOP] = (k % 2 == 0);
         repeat (5) @(negedge clock);
      end
      bus.btn_in[BTN_CHOP] = 1'b1;
      cnt = 0;
      while (bus.level_out[BTN_CHOP] !== 1'b1 && cnt < 60) begin
         @(posedge clock);
         #1;
         cnt++;
      end
      check("bounce_latency", cnt, 18);
      repeat (10) @(negedge clock);
      check("bounce_presses", press_cnt[BTN_CHOP] - p0, 1);
      bus.btn_in[BTN_CHOP] = 1'b0;
      repeat (30) @(negedge clock);

      // glitch on left
      p0 = press_cnt[BTN_LEFT];
      seen = 1'b0;
      bus.btn_in[BTN_LEFT] = 1'b1;
      repeat (10) @(negedge clock);
      bus.btn_in[BTN_LEFT] = 1'b0;
      repeat (40) begin
         @(negedge clock);
         if (bus.level_out[BTN_LEFT] !== 1'b0) seen = 1'b1;
      end
      check("glitch_level", seen, 1'b0);
      check("glitch_press", press_cnt[BTN_LEFT] - p0, 0);

      // vsync frozen: short taps on right and carry accumulate into one snapshot
      vs_run = 1'b0;
      repeat (80) @(negedge clock);
      bus.btn_in[BTN_RIGHT] = 1'b1;
      repeat (40) @(negedge clock);
      bus.btn_in[BTN_RIGHT] = 1'b0;
      repeat (10) @(negedge clock);
      bus.btn_in[BTN_CARRY] = 1'b1;
      repeat (40) @(negedge clock);
      bus.btn_in[BTN_CARRY] = 1'b0;
      repeat (30) @(negedge clock);
      check("hold_frame_press", bus.frame_press, 6'b000000);
      @(posedge clock);
      #1;
      kick_req++;
      wait_tick("tap_tick1");
      check("tap_frame_press", bus.frame_press, 6'b010001);
      check("tap_frame_level", bus.frame_level, 6'b000000);
      kick_req++;
      wait_tick("tap_tick2");
      check("tap_next_press", bus.frame_press, 6'b000000);

      // carry press landing exactly on the frame update
      @(negedge clock);
      bus.btn_in[BTN_CARRY] = 1'b1;
      repeat (12) begin
         @(posedge clock);
         #1;
      end
      kick_req++;
      wait_tick("coinc_tick1");
      check("coinc_press_out", bus.press_out[BTN_CARRY], 1'b1);
      check("coinc_frame_press", bus.frame_press[BTN_CARRY], 1'b1);
      repeat (5) @(negedge clock);
      bus.btn_in[BTN_CARRY] = 1'b0;
      repeat (30) @(negedge clock);
      @(posedge clock);
      #1;
      kick_req++;
      wait_tick("coinc_tick2");
      check("coinc_next_press", bus.frame_press[BTN_CARRY], 1'b0);
      check("coinc_next_level", bus.frame_level[BTN_CARRY], 1'b0);

      // auto-repeat: up repeats, chop does not
      vs_run = 1'b1;
      @(negedge clock);
      bus.btn_in[BTN_UP]   = 1'b1;
      bus.btn_in[BTN_CHOP] = 1'b1;
      cnt = 0;
      while (bus.press_out[BTN_UP] !== 1'b1 && cnt < 200) begin
         @(posedge clock);
         #1;
         cnt++;
      end
      check("up_press_seen", bus.press_out[BTN_UP], 1'b1);
      ticks = 0;
      hits3 = 0;
      hits1 = 0;
      cnt   = 0;
      while (ticks < 10 && cnt < 2000) begin
         if (bus.frame_tick === 1'b1) begin
            ticks++;
            if (bus.frame_press[BTN_UP] === 1'b1) hits3++;
            if (bus.frame_press[BTN_CHOP] === 1'b1) hits1++;
         end
         @(posedge clock);
         #1;
         cnt++;
      end
      check("repeat_ticks", ticks, 10);
      check("repeat_up_hits", hits3, 5);
      check("repeat_chop_hits", hits1, 1);
      @(negedge clock);
      bus.btn_in[BTN_UP]   = 1'b0;
      bus.btn_in[BTN_CHOP] = 1'b0;
      repeat (40) @(negedge clock);

      // reset while down is held
      bus.btn_in[BTN_DOWN] = 1'b1;
      repeat (40) @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_outputs", {bus.level_out, bus.press_out, bus.frame_level, bus.frame_press,
                              bus.frame_tick}, '0);
      reset = 1'b0;
      cnt = 0;
      while (bus.press_out[BTN_DOWN] !== 1'b1 && cnt < 60) begin
         @(posedge clock);
         #1;
         cnt++;
      end
      check("reset_press_latency", cnt, 18);
      @(negedge clock);
      bus.btn_in[BTN_DOWN] = 1'b0;
      repeat (30) @(negedge clock);

      // random toggling across all buttons, including sub-debounce glitches
      for (int k = 0; k < 70; k++) begin
         bus.btn_in = bus.btn_in ^ btn_vec_t'(1 << $urandom_range(0, 5));
         repeat ($urandom_range(3, 40)) @(negedge clock);
      end
      bus.btn_in = '0;
      repeat (150) @(negedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
